// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the issue/scoreboard logic.
// No logic, so no latency.
// No handshake of its own; declarations only.
package lc3b_types;

   typedef logic [2:0] lc3b_reg;

   localparam int NUM_REGS   = 8;
   localparam int PEND_CNT_W = 2;

   typedef logic [PEND_CNT_W-1:0] lc3b_pend_cnt;

endpackage

// File: rtl/scoreboard_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// Count updates one cycle after inc/dec/clr; status outputs follow the registered count.
// No handshake; saturation and underflow are clamped here as a backstop to the caller's gating.
module scoreboard_counter #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         nonzero,
   output logic         at_max
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   // Count register: clear wins, simultaneous inc and dec cancel, never wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec && cnt != MAX_V) begin
         cnt <= cnt + W'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign nonzero = (cnt != '0);
   assign at_max  = (cnt == MAX_V);

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the 8 LC-3b registers; stalls RAW hazards and counter saturation.
// issue_ready is combinational (zero latency); busy/err reflect state registered at the last edge.
// Holds off issue (issue_ready low) on hazard, saturation or flush; writeback is never back-pressured.
module regfile_scoreboard
   import lc3b_types::*;
#(
   parameter int CNT_W     = PEND_CNT_W,
   parameter int MAX_PEND  = 3,
   parameter bit WB_BYPASS = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  lc3b_reg             issue_src_a,
   input  lc3b_reg             issue_src_b,
   input  logic                issue_use_a,
   input  logic                issue_use_b,
   input  lc3b_reg             issue_dest,
   input  logic                issue_wr,
   input  logic                wb_valid,
   input  lc3b_reg             wb_dest,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy,
   output logic                stall,
   output logic                err
);

   logic [CNT_W-1:0]    pend [NUM_REGS];
   logic [NUM_REGS-1:0] nz;
   logic [NUM_REGS-1:0] at_max;
   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] dec;

   logic byp_a, byp_b;
   logic hazard_a, hazard_b;
   logic sat;
   logic fire;

   // Hazard, saturation and ready decode for the instruction at the issue port.
   always_comb begin
      byp_a    = 1'b0;
      byp_b    = 1'b0;
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      sat      = 1'b0;
      // A last outstanding write landing this cycle can be forwarded downstream.
      if (WB_BYPASS) begin
         byp_a = wb_valid && (wb_dest == issue_src_a) && (pend[issue_src_a] == CNT_W'(1));
         byp_b = wb_valid && (wb_dest == issue_src_b) && (pend[issue_src_b] == CNT_W'(1));
      end
      hazard_a = issue_use_a && nz[issue_src_a] && !byp_a;
      hazard_b = issue_use_b && nz[issue_src_b] && !byp_b;
      // A writeback to the destination frees a slot this cycle, so a full counter can still take one.
      sat      = issue_wr && at_max[issue_dest] && !(wb_valid && (wb_dest == issue_dest));
   end

   assign issue_ready = !flush && !hazard_a && !hazard_b && !sat;
   assign stall       = issue_valid && !issue_ready;
   assign fire        = issue_valid && issue_ready;
   assign busy        = nz;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
      assign inc[r] = fire && issue_wr && (issue_dest == lc3b_reg'(r));
      assign dec[r] = wb_valid && (wb_dest == lc3b_reg'(r)) && nz[r];

      scoreboard_counter #(
         .W   (CNT_W),
         .MAX (MAX_PEND)
      ) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (flush),
         .inc     (inc[r]),
         .dec     (dec[r]),
         .cnt     (pend[r]),
         .nonzero (nz[r]),
         .at_max  (at_max[r])
      );
   end

   // Sticky error on writeback to an idle register; a flush-cycle writeback is discarded, not flagged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else if (wb_valid && !flush && !nz[wb_dest]) begin
         err <= 1'b1;
      end
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks pending (issued, not yet written back) writes to each of the 8 LC-3b architectural registers.
- Sits between decode/issue and the register file.
- Stalls any instruction that has a RAW hazard on a source register, or whose destination's pending count would saturate.
- Writeback retires pending entries; flush discards all in-flight tracking.

Parameters:
- CNT_W, 2, width of each per-register pending counter.
- MAX_PEND, 3, maximum outstanding writes per register; must be ≤ 2^CNT_W − 1.
- WB_BYPASS, 0, when 1, a same-cycle writeback to a source register whose count is 1 clears that hazard combinationally (needs a forwarding path downstream).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  scoreboard accepts; issue fires when issue_valid & issue_ready.
- issue_src_a  in  3  source A register (lc3b_reg).
- issue_src_b  in  3  source B register (lc3b_reg).
- issue_use_a  in  1  source A is actually read.
- issue_use_b  in  1  source B is actually read.
- issue_dest  in  3  destination register (lc3b_reg).
- issue_wr  in  1  instruction writes issue_dest.
- wb_valid  in  1  writeback of one register this cycle (same cycle as regfile load).
- wb_dest  in  3  register being written back.
- flush  in  1  pipeline flush; discard all pending state.
- busy  out  8  bit r = 1 when pending count of register r is nonzero (registered view).
- stall  out  1  issue_valid & ~issue_ready.
- err  out  1  sticky error: writeback to a register with zero pending count.

Behaviour:
- State: pend[0..7] (CNT_W bits each) and err flag. Reset (async, reset_n low) sets all pend = 0 and err = 0. Outputs under reset: busy = 0, issue_ready = 1, stall = 0, err = 0.
- hazard_a = issue_use_a & (pend[src_a] != 0), excluding the bypass case. Same for hazard_b.
- Bypass case (WB_BYPASS = 1 only): wb_valid & wb_dest == src & pend[src] == 1.
- sat = issue_wr & (pend[dest] == MAX_PEND), excluding the case where wb_valid & wb_dest == dest (the slot frees this cycle).
- issue_ready = ~flush & ~hazard_a & ~hazard_b & ~sat. Purely combinational; no latency.
- Per-register update at posedge clk, evaluated for each r independently:
  - inc = issue fires & issue_wr & dest == r.
  - dec = wb_valid & wb_dest == r & pend[r] != 0.
  - inc & dec: count unchanged. inc only: +1. dec only: −1.
  - Counters never wrap: sat blocks the increment at MAX_PEND; dec is gated at 0.
- err: wb_valid with pend[wb_dest] == 0 sets err at the next edge. It stays set until reset; flush does not clear it. The counter stays at 0.
- Flush has priority over everything. All pend clear at the next edge. Same-cycle issue and writeback are ignored for counting, and issue_ready = 0 during flush. A writeback arriving in the flush cycle does not set err.
- Self-dependence (src == dest with a nonzero count) stalls as normal RAW. Src == dest with a zero count issues, and the count becomes 1.
- busy reflects registered pend only; it does not include same-cycle issue/writeback effects.
- A reset_n assertion mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package (lc3b_types): use the existing lc3b_reg. Add localparam NUM_REGS = 8 and typedef lc3b_pend_cnt (logic [CNT_W-1:0]) if CNT_W is fixed globally.
- One natural sub-module: scoreboard_counter. It is a single saturating up/down counter with inc, dec, clr, async reset_n, a nonzero output and an at_max output, instantiated 8 times. Hazard/ready logic stays in the top level.

Test Plan:
- Reset, then issue dest=R3 (issue_wr=1) -> next cycle busy=8'b0000_1000. Then issue with src_a=R3, use_a=1 -> stall=1, issue_ready=0.
- R3 pending=1, wb_valid with wb_dest=R3, dependent instruction waiting, WB_BYPASS=0 -> stall in the wb cycle, issue accepted the following cycle, busy=0. With WB_BYPASS=1 -> accepted in the wb cycle.
- Three issues to R5 back-to-back -> pend[5]=3. Fourth issue -> stall. Fourth issue plus same-cycle wb R5 -> accepted, pend[5] stays 3.
- Same cycle: issue dest=R2 and wb R2 with pend[2]=1 -> pend[2]=1 after the edge, err=0.
- pend = R1:2, R6:1, then flush with a simultaneous issue dest=R0 -> next cycle busy=0, R0 not counted, issue_ready=0 during flush.
- wb_valid wb_dest=R7 with pend[7]=0 -> err=1 next cycle, stays 1 through a flush. Assert reset_n low mid-cycle -> err=0 and busy=0 immediately.
